ysyx_24110015_ifu_fetch: RTL
============================

# ysyx_24110015_ifu_fetch

Instruction fetch stage for the ysyx_24110015 RV32E multi-cycle core. It sits between the instruction memory bus and the decode stage (IDU). It holds the architectural PC and issues one read per instruction on an AXI-lite-style read channel (AR/R). It presents the fetched word to the IDU with a valid/ready handshake, then waits for the execute stage to return the next PC before fetching again. Exactly one instruction is in flight at any time.

## Interface
Parameters:
- RESET_PC, 32'h8000_0000, PC value loaded on reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- araddr  out  32  fetch address; always equals pc.
- arvalid  out  1  read request valid.
- arready  in  1  memory accepts the request.
- rdata  in  32  returned instruction word.
- rresp  in  2  response code; nonzero = error.
- rvalid  in  1  response valid.
- rready  out  1  fetch unit accepts the response.
- inst  out  32  registered instruction presented to the IDU.
- pc  out  32  PC of `inst`.
- inst_valid  out  1  `inst` and `pc` are valid.
- inst_ready  in  1  IDU consumes the instruction.
- pc_next  in  32  next PC from the EXU.
- pc_next_valid  in  1  `pc_next` is valid; the current instruction is retired.
- fetch_err  out  1  one-cycle pulse on a bus error or misaligned PC.
- fetch_cnt  out  32  count of instructions handed to the IDU.

## Operation
- The FSM has five states: IDLE, FETCH, WAIT, VALID, EXEC.
- **IDLE:** all handshake outputs are 0. Moves to FETCH on the next edge unconditionally.
- **FETCH:** arvalid=1.
  - If pc[1:0]!=0, no request is issued: arvalid is forced to 0, inst<=32'h0, fetch_err pulses, and the FSM goes to VALID.
  - On arvalid&&arready, go to WAIT.
- **WAIT:** rready=1.
  - On rvalid: inst<=rdata and go to VALID.
  - If rresp!=0, also pulse fetch_err in the following cycle. The word is still delivered; the IDU treats it as-is.
- **VALID:** inst_valid=1; inst and pc are stable.
  - On inst_ready: fetch_cnt increments by 1 (wraps 32'hFFFF_FFFF -> 0) and the FSM goes to EXEC.
  - If pc_next_valid is also high in the same cycle (single-cycle execute), pc<=pc_next and the FSM goes directly to FETCH.
- **EXEC:** on pc_next_valid, pc<=pc_next and go to FETCH.
- pc_next_valid in IDLE, FETCH or WAIT is ignored; pc is unchanged.
- rvalid outside WAIT is ignored (rready=0).
- arvalid, once raised, is held with araddr constant until arready. Deassertion before the handshake is not allowed.
- Reset mid-transaction returns the FSM to IDLE immediately. Any outstanding R beat is dropped; the memory must also be in reset.

## Timing
Values during reset:
- pc=RESET_PC, inst=32'h0, fetch_cnt=0.
- State=IDLE.
- arvalid=rready=inst_valid=fetch_err=0.

Cycle-level behaviour:
- First arvalid is raised 1 cycle after rst deasserts (IDLE->FETCH edge).
- With zero-wait memory (arready immediate, rvalid one cycle after the AR handshake), the path from FETCH entry to inst_valid is:
  - FETCH: 1 cycle
  - WAIT: 1 cycle
  - VALID from the 3rd cycle onward
- Refetch after pc_next_valid starts in the next cycle (FETCH).
- Best-case throughput is one instruction per 3 cycles.
- fetch_err is registered: it goes high the cycle after the triggering event and lasts exactly one cycle.
- All outputs are driven from registers or decoded from the state register. There is no combinational path from any input to any output.

## Test plan
- **Reset and first fetch:** hold rst=0 for 3 cycles, then release.
  - During reset: pc=32'h8000_0000, arvalid=0.
  - One cycle after release: arvalid=1, araddr=32'h8000_0000.
- **Zero-wait fetch:** arready=1, then rvalid=1 with rdata=32'h0010_0093 one cycle later.
  - inst_valid=1 with inst=32'h0010_0093 in the 3rd cycle after FETCH entry.
  - inst_ready=1 -> fetch_cnt=1.
- **Back-pressure:** arready held 0 for 4 cycles, then 1.
  - arvalid and araddr stay stable throughout.
  - Hold inst_ready=0 for 5 cycles in VALID; inst must not change.
- **Redirect:** in EXEC, drive pc_next=32'h8000_0100 with pc_next_valid=1.
  - Next cycle: araddr=32'h8000_0100.
  - Same-cycle inst_ready with pc_next_valid skips EXEC.
- **Errors:**
  - rresp=2'b10 -> fetch_err pulses 1 cycle and the word is still delivered.
  - pc_next=32'h8000_0102 -> no AR issued, inst=0, fetch_err pulses.
- **Async reset in WAIT:** drop rst mid-cycle.
  - Outputs clear immediately without waiting for a clock edge.
  - The next fetch after release is at RESET_PC.

Source files
------------

// File: rtl/ysyx_24110015_ifu_fetch.sv
// Instruction fetch stage of the ysyx_24110015 RV32E multi-cycle core.
// Holds the PC, fetches one word per instruction over AR/R and hands it to the IDU.
module ysyx_24110015_ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,

    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,

    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready,

    output logic [31:0] inst,
    output logic [31:0] pc,
    output logic        inst_valid,
    input  logic        inst_ready,

    input  logic [31:0] pc_next,
    input  logic        pc_next_valid,

    output logic        fetch_err,
    output logic [31:0] fetch_cnt
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_VALID = 3'd3,
        S_EXEC  = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic        fetch_err_q, fetch_err_d;
    logic        pc_misaligned;

    assign pc_misaligned = (pc_q[1:0] != 2'b00);

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case leaves one unassigned (no latches).
        state_d     = state_q;
        pc_d        = pc_q;
        inst_d      = inst_q;
        fetch_cnt_d = fetch_cnt_q;
        fetch_err_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end

            S_FETCH: begin
                // A misaligned PC never reaches the bus; a zero word is delivered instead.
                if (pc_misaligned) begin
                    inst_d      = 32'h0;
                    fetch_err_d = 1'b1;
                    state_d     = S_VALID;
                end else if (arready) begin
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                if (rvalid) begin
                    inst_d      = rdata;
                    fetch_err_d = (rresp != 2'b00);
                    state_d     = S_VALID;
                end
            end

            S_VALID: begin
                if (inst_ready) begin
                    fetch_cnt_d = fetch_cnt_q + 32'd1;
                    if (pc_next_valid) begin
                        pc_d    = pc_next;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_EXEC;
                    end
                end
            end

            S_EXEC: begin
                if (pc_next_valid) begin
                    pc_d    = pc_next;
                    state_d = S_FETCH;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample the same pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            inst_q      <= 32'h0;
            fetch_cnt_q <= 32'h0;
            fetch_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            inst_q      <= inst_d;
            fetch_cnt_q <= fetch_cnt_d;
            fetch_err_q <= fetch_err_d;
        end
    end

    // Handshake outputs decode the state register only, so no input reaches an output combinationally.
    assign arvalid    = (state_q == S_FETCH) && !pc_misaligned;
    assign rready     = (state_q == S_WAIT);
    assign inst_valid = (state_q == S_VALID);
    assign araddr     = pc_q;
    assign pc         = pc_q;
    assign inst       = inst_q;
    assign fetch_err  = fetch_err_q;
    assign fetch_cnt  = fetch_cnt_q;

endmodule
